// File: rtl/expression_solver_pkg.sv
// Shared definitions for the quadratic expression solver:
// FSM state encoding, datapath select codes, default widths and the
// value driven onto result when saturation is enabled.
package expression_solver_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_XWIDTH = 8;

    // Result presented on overflow in saturating builds.
    localparam logic [DEF_WIDTH-1:0] SAT_VALUE = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SQ   = 3'd1,
        S_AXX  = 3'd2,
        S_BX   = 3'd3,
        S_ADD1 = 3'd4,
        S_ADD2 = 3'd5,
        S_DONE = 3'd6
    } state_t;

    // Which operation the shared multiplier/adder performs this cycle.
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_SQ   = 3'd1,
        SEL_AXX  = 3'd2,
        SEL_BX   = 3'd3,
        SEL_ADD1 = 3'd4,
        SEL_ADD2 = 3'd5
    } sel_t;

endpackage

// File: rtl/expression_solver_datapath.sv
// Combinational datapath for the expression solver: one shared
// multiplier, one shared adder, their operand muxes, and the overflow
// detect for whichever operation the select code picks.
module expression_solver_datapath
    import expression_solver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  sel_t             sel,
    input  logic [WIDTH-1:0] x_ext,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] t1,
    input  logic [WIDTH-1:0] t2,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic               use_add;

    // Operand muxes: route the registered operands to the shared units.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        add_a   = '0;
        add_b   = '0;
        use_add = 1'b0;
        case (sel)
            SEL_SQ:   begin mul_a = x_ext; mul_b = x_ext; end
            SEL_AXX:  begin mul_a = a;     mul_b = t1;    end
            SEL_BX:   begin mul_a = b;     mul_b = x_ext; end
            SEL_ADD1: begin add_a = t1;    add_b = t2;  use_add = 1'b1; end
            SEL_ADD2: begin add_a = acc;   add_b = c;   use_add = 1'b1; end
            default:  begin end
        endcase
    end

    // Full-width product and carry-extended sum; the low WIDTH bits are
    // kept and anything above them is reported as overflow.
    always_comb begin
        prod = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
        sum  = {1'b0, add_a} + {1'b0, add_b};
        if (use_add) begin
            value = sum[WIDTH-1:0];
            ovf   = sum[WIDTH];
        end else begin
            value = prod[WIDTH-1:0];
            ovf   = (sel != SEL_NONE) && (|prod[2*WIDTH-1:WIDTH]);
        end
    end

endmodule

// File: rtl/expression_solver_unit.sv
// Sequential evaluator of result = A*X^2 + B*X + C (unsigned).
// Five compute cycles share one multiplier and one adder; the result
// and flags are registered at the last step and held through DONE.
// Optional build macro: EXPRESSION_SOLVER_SATURATE_EN -- when defined,
// an overflowing computation presents all ones instead of wrapping.
// dbg_state exposes the FSM state for observation.
module expression_solver_unit
    import expression_solver_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int XWIDTH = DEF_XWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XWIDTH-1:0] X,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [WIDTH-1:0]  C,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              overflow,
    output logic              completed,
    output logic [2:0]        dbg_state
);

    state_t state;
    state_t state_nxt;
    sel_t   sel;

    logic [XWIDTH-1:0] x_r;
    logic [WIDTH-1:0]  a_r, b_r, c_r;
    logic [WIDTH-1:0]  t1, t2, acc;
    logic              ovf_r;

    logic [WIDTH-1:0]  dp_value;
    logic              dp_ovf;
    logic [WIDTH-1:0]  fin_result;
    logic              fin_zero;
    logic              fin_ovf;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: start is only looked at in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SQ;
            S_SQ:    state_nxt = S_AXX;
            S_AXX:   state_nxt = S_BX;
            S_BX:    state_nxt = S_ADD1;
            S_ADD1:  state_nxt = S_ADD2;
            S_ADD2:  state_nxt = S_DONE;
            S_DONE:  if (!start) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: datapath select and the completion flag.
    always_comb begin
        sel       = SEL_NONE;
        completed = 1'b0;
        case (state)
            S_SQ:    sel = SEL_SQ;
            S_AXX:   sel = SEL_AXX;
            S_BX:    sel = SEL_BX;
            S_ADD1:  sel = SEL_ADD1;
            S_ADD2:  sel = SEL_ADD2;
            S_DONE:  completed = 1'b1;
            default: begin end
        endcase
    end

    assign dbg_state = state;

    expression_solver_datapath #(.WIDTH(WIDTH)) u_datapath (
        .sel   (sel),
        .x_ext ({{(WIDTH-XWIDTH){1'b0}}, x_r}),
        .a     (a_r),
        .b     (b_r),
        .c     (c_r),
        .t1    (t1),
        .t2    (t2),
        .acc   (acc),
        .value (dp_value),
        .ovf   (dp_ovf)
    );

    // Final values captured at ADD2: sticky overflow, optional saturation.
    always_comb begin
        fin_ovf    = ovf_r | dp_ovf;
        fin_result = dp_value;
`ifdef EXPRESSION_SOLVER_SATURATE_EN
        if (fin_ovf) fin_result = WIDTH'(SAT_VALUE);
`endif
        fin_zero   = (fin_result == '0);
    end

    // Operand latch, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            c_r      <= '0;
            t1       <= '0;
            t2       <= '0;
            acc      <= '0;
            ovf_r    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r      <= X;
                        a_r      <= A;
                        b_r      <= B;
                        c_r      <= C;
                        ovf_r    <= 1'b0;
                        result   <= '0;
                        zero     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                S_SQ, S_AXX: begin
                    t1    <= dp_value;
                    ovf_r <= ovf_r | dp_ovf;
                end
                S_BX: begin
                    t2    <= dp_value;
                    ovf_r <= ovf_r | dp_ovf;
                end
                S_ADD1: begin
                    acc   <= dp_value;
                    ovf_r <= ovf_r | dp_ovf;
                end
                S_ADD2: begin
                    acc      <= dp_value;
                    ovf_r    <= fin_ovf;
                    result   <= fin_result;
                    zero     <= fin_zero;
                    overflow <= fin_ovf;
                end
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_expression_solver_unit.sv
// Directed bench for expression_solver_unit. A driver issues requests
// and pushes the hand-computed response into exp_q; an independent
// monitor pops and compares each time completed rises.
module tb_expression_solver_unit;

    localparam int W  = 16;
    localparam int XW = 8;
    localparam int EW = W + 2;

`ifdef EXPRESSION_SOLVER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [XW-1:0] X;
    logic [W-1:0]  A, B, C;
    logic [W-1:0]  result;
    logic          zero;
    logic          overflow;
    logic          completed;
    logic [2:0]    dbg_state;

    logic [EW-1:0] exp_q[$];
    int            iss_q[$];
    int            cyc;
    int            n_cmp;
    int            n_fail;
    logic          prev_c;

    expression_solver_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .A         (A),
        .B         (B),
        .C         (C),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .completed (completed),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic scramble();
        X = XW'($urandom_range(0, 255));
        A = W'($urandom_range(0, 65535));
        B = W'($urandom_range(0, 65535));
        C = W'($urandom_range(0, 65535));
    endtask

    // ---------------- driver ----------------
    // Issues one request. hold=1 keeps start high and returns at the
    // first negedge where completed is seen.
    task automatic issue(input logic [XW-1:0] x, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] r, input bit z, input bit o,
                         input bit hold);
        logic [W-1:0] er;
        bit           ez;
        int           i;
        er = r;
        ez = z;
        if (o && SAT) begin
            er = '1;
            ez = 1'b0;
        end
        @(negedge clk);
        X = x; A = a; B = b; C = c;
        start = 1'b1;
        exp_q.push_back({er, ez, o});
        iss_q.push_back(cyc);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
            scramble();
            @(negedge clk);
            start = 1'b1;      // mid-computation, must be ignored
            @(negedge clk);
            start = 1'b0;
        end
        i = 0;
        while (!completed && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (!completed) begin
            n_cmp++;
            n_fail++;
            $display("FAIL completion_timeout: act=0 exp=1 (t=%0t)", $time);
        end
        if (!hold) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial prev_c = 1'b0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        int            t;
        if (!rst && completed && !prev_c) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_completion: act=1 exp=0 (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                t = iss_q.pop_front();
                check("result",   32'(result),   32'(e[EW-1:2]));
                check("zero",     32'(zero),     32'(e[1]));
                check("overflow", 32'(overflow), 32'(e[0]));
                check("latency",  32'(cyc - t),  32'd6);
            end
        end
        prev_c = completed;
    end

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        X = '0; A = '0; B = '0; C = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_result",    32'(result),    32'd0);
        check("reset_zero",      32'(zero),      32'd0);
        check("reset_overflow",  32'(overflow),  32'd0);
        check("reset_completed", 32'(completed), 32'd0);
        check("reset_state",     32'(dbg_state), 32'd0);

        //     X    A         B         C         result   z  o
        issue(15,  96,       3,        1,        21646,   0, 0, 0);
        issue(0,   5,        7,        0,        0,       1, 0, 0);
        issue(255, 2,        0,        0,        64514,   0, 1, 0);
        issue(1,   16'hFFFF, 0,        1,        0,       1, 1, 0);
        issue(10,  1,        1,        1,        111,     0, 0, 0);
        issue(200, 1,        100,      5,        60005,   0, 0, 0);
        issue(0,   0,        0,        16'hFFFF, 16'hFFFF,0, 0, 0);
        issue(255, 1,        255,      0,        64514,   0, 1, 0);
        issue(16,  256,      0,        0,        0,       1, 1, 0);
        issue(255, 0,        300,      0,        10964,   0, 1, 0);
        issue(1,   0,        16'hFFF0, 16'h20,   16,      0, 1, 0);

        // Reset two cycles into a computation aborts it.
        @(negedge clk);
        X = 15; A = 96; B = 3; C = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_result",    32'(result),    32'd0);
        check("abort_zero",      32'(zero),      32'd0);
        check("abort_overflow",  32'(overflow),  32'd0);
        check("abort_completed", 32'(completed), 32'd0);
        check("abort_state",     32'(dbg_state), 32'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (completed) bad++;
        end
        check("abort_no_completion", 32'(bad), 32'd0);
        issue(15, 96, 3, 1, 21646, 0, 0, 0);

        // start held high: DONE persists, operand changes ignored.
        issue(3, 2, 4, 5, 35, 0, 0, 1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            scramble();
            @(negedge clk);
            if (!completed || result !== 16'd35) bad++;
        end
        check("hold_done_stable", 32'(bad), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("release_completed", 32'(completed), 32'd0);
        check("release_result",    32'(result),    32'd35);
        check("release_zero",      32'(zero),      32'd0);
        issue(4, 2, 4, 5, 53, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/expression_solver_unit.md
# expression_solver_unit

Sequential arithmetic unit that evaluates the quadratic result = A·X² + B·X + C over unsigned operands. It uses one shared multiplier and one adder, sequenced by a small FSM. It is a self-contained compute leaf: the host pulses `start`, waits for `completed`, then reads `result` with its `zero`/`overflow` flags.

## Interface
- `WIDTH`, 16: width of A, B, C, result and internal accumulators.
- `XWIDTH`, 8: width of X; zero-extended to `WIDTH` internally.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled in IDLE only.
- `X`  in  XWIDTH  variable operand.
- `A`  in  WIDTH  quadratic coefficient.
- `B`  in  WIDTH  linear coefficient.
- `C`  in  WIDTH  constant term.
- `result`  out  WIDTH  low `WIDTH` bits of A·X²+B·X+C (wrapped), or the saturated value when configured.
- `zero`  out  1  `result` == 0.
- `overflow`  out  1  some intermediate product or sum exceeded `WIDTH` bits (sticky per computation).
- `completed`  out  1  high while in DONE.

## Operation
- **Arithmetic:** all values unsigned. Products are full 2·WIDTH; sums are WIDTH+1.
  - Overflow sets if a product's upper half is nonzero or a sum carries out.
  - The working value keeps the low `WIDTH` bits.
- **FSM states:** IDLE → SQ → AXX → BX → ADD1 → ADD2 → DONE.
  - IDLE, `start`=1: latch X, A, B, C; clear `overflow`, `zero`, `result`; go to SQ.
  - SQ: t1 = X·X. Never overflows for XWIDTH=8.
  - AXX: t1 = A·t1; overflow check.
  - BX: t2 = B·X; overflow check.
  - ADD1: acc = t1 + t2; carry check.
  - ADD2: acc = acc + C; carry check. Register `result`, `zero` and the final `overflow`; go to DONE.
  - DONE: `completed`=1. Stay while `start`=1. When `start`=0, return to IDLE; `result`/`zero`/`overflow` hold.
- Operand inputs are ignored after latching; changes mid-computation have no effect.
- `start` is ignored outside IDLE and DONE.
- `zero` always reflects the registered `result`, after wrap or saturation.

## Timing
- **Reset:** state IDLE; `result`=0, `zero`=0, `overflow`=0, `completed`=0, internal registers 0.
  - Applies at the first rising edge with `rst`=1 and overrides `start`.
  - Reset mid-computation aborts the computation; no partial result is exposed.
- **Latency:** `start` sampled at edge k → `result`/`zero`/`overflow`/`completed` valid after edge k+5.
- **Start held high:** DONE persists with `completed`=1. No restart until `start` has been low for at least one cycle (DONE→IDLE).
- **Back-to-back:** minimum issue interval is 7 cycles (5 compute + DONE exit + IDLE sample).

## Configuration
- `EXPRESSION_SOLVER_SATURATE_EN` defined: when `overflow`=1 at ADD2, `result` = all ones (16'hFFFF) and `zero`=0.
- Not defined: `result` wraps modulo 2^WIDTH.
- `overflow` behaves identically in both builds.

## Structure
- **Package `expression_solver_pkg`:** FSM state enum, default `WIDTH`/`XWIDTH` constants, saturation constant.
- **Sub-module `expression_solver_datapath`:** shared multiplier, adder, operand muxes and overflow detection.
  - Controlled by a select code from the FSM in the top.

## Test plan
- X=15, A=96, B=3, C=1, `start` at edge k → after edge k+5: `result`=21646, `zero`=0, `overflow`=0, `completed`=1.
- X=0, A=5, B=7, C=0 → `result`=0, `zero`=1, `overflow`=0.
- X=255, A=2, B=0, C=0 → `overflow`=1; `result`=64514 (wrap) or 16'hFFFF with `EXPRESSION_SOLVER_SATURATE_EN`.
- X=1, A=16'hFFFF, B=0, C=1 → adder carry: `overflow`=1; wrap build gives `result`=0, `zero`=1.
- `rst` asserted two cycles after `start` → next edge: IDLE, all outputs 0; a new `start` yields the correct result 5 cycles later.
- `start` held high → `completed` stays 1 and X changes are ignored. `start` low → `completed` falls next edge, `result` holds. Re-raising `start` recomputes with the new operands.
